// File: rtl/ifu_mem_fill.sv
// Miss-fill engine behind the IFU instruction cache: takes one line miss at a time,
// issues a single burst read to instruction memory, assembles the beats into a line
// and returns {tag, line} to the cache with a one-cycle fill pulse.
// Optional watchdog: define IFU_FILL_TIMEOUT_EN to abort fills that stall for TIMEOUT cycles.
module ifu_mem_fill #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = 128
`ifdef IFU_FILL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT    = 64
`endif
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
  input  logic                  cache_reqValidIn,
  output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
  output logic [LINE_WIDTH-1:0] cache_rspLineOut,
  output logic                  cache_rspValidOut,
  output logic                  fill_busyOut,
  output logic                  mem_rdReqOut,
  output logic [ADDR_WIDTH-1:0] mem_rdAddrOut,
  input  logic                  mem_rdGntIn,
  input  logic [WORD_WIDTH-1:0] mem_rdDataIn,
  input  logic                  mem_rdDataValidIn,
  output logic                  fill_errOut
);

  localparam int unsigned BEATS = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWaitData, StResp} state_e;

  state_e                state_q, state_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

`ifdef IFU_FILL_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
`endif

  // Next-state: request latch, beat assembly and (optionally) the stall watchdog.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
`ifdef IFU_FILL_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cache_reqValidIn) begin
          tag_d   = cache_reqTagIn;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_rdGntIn) begin
          cnt_d   = '0;
          state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (mem_rdDataValidIn) begin
          line_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = mem_rdDataIn;
          // Counter holds on the last beat rather than wrapping.
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef IFU_FILL_TIMEOUT_EN
    // Watchdog starts at zero on REQ entry; expiry overrides any beat completion.
    if (state_q == StIdle) begin
      wdog_d = '0;
    end else if (state_q == StReq || state_q == StWaitData) begin
      if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
        state_d = StIdle;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  // State register; reset discards any partial line.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      tag_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
`ifdef IFU_FILL_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
`ifdef IFU_FILL_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  // Outputs come straight from registers or state decode.
  assign cache_rspTagOut   = tag_q;
  assign cache_rspLineOut  = line_q;
  assign cache_rspValidOut = (state_q == StResp);
  assign fill_busyOut      = (state_q != StIdle);
  assign mem_rdReqOut      = (state_q == StReq);
  assign mem_rdAddrOut     = {tag_q, {OFFSET_WIDTH{1'b0}}};
`ifdef IFU_FILL_TIMEOUT_EN
  assign fill_errOut       = err_q;
`else
  assign fill_errOut       = 1'b0;
`endif

endmodule
